// File: rtl/ov5640_init_pkg.sv
// Shared types and constants for the OV5640 init-table sequencer.
package ov5640_init_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DELAY = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } init_state_t;

  // Field positions inside a 24-bit table entry {reg_addr[15:0], data[7:0]}
  localparam int REG_MSB = 23;
  localparam int REG_LSB = 8;
  localparam int DAT_MSB = 7;

  // Default timing: 5 ms post-reset delay and 2 ms write timeout at 50 MHz
  localparam int DEF_DELAY_CYCLES   = 250000;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  // Larger of two integers, used to size the shared timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov5640_init_timer.sv
// Loadable down-counter shared by the post-reset delay and the write timeout.
// A load of value L makes 'expired' pulse for one cycle exactly L cycles
// after the load cycle. A load value of 0 never expires.
module ov5640_init_timer
  import ov5640_init_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_r;
  logic         expired_r;

  // Count down toward zero; the expiry pulse is registered one step ahead
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {W{1'b0}};
      expired_r <= 1'b0;
    end else if (load) begin
      cnt_r     <= load_val;
      expired_r <= (load_val == W'(1));
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r     <= cnt_r - W'(1);
      expired_r <= (cnt_r == W'(2));
    end else begin
      cnt_r     <= cnt_r;
      expired_r <= 1'b0;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/ov5640_init_ctrl.sv
// Walks the OV5640 init table, issuing one SCCB write per entry with
// post-software-reset delay, NACK/timeout retry and done/error reporting.
module ov5640_init_ctrl
  import ov5640_init_pkg::*;
#(
  parameter int INIT_CNT       = 250,
  parameter int ADDR_WIDTH     = 8,
  parameter int DELAY_AFTER    = 1,
  parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_busy,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
);

  localparam int TW = $clog2(max_int(DELAY_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0]         DELAY_LOAD = TW'(DELAY_CYCLES);
  // The issue cycle itself counts toward the timeout window, so the retry
  // or error takes effect exactly TIMEOUT_CYCLES after the request.
  localparam logic [TW-1:0]         TO_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] DELAY_IDX  = ADDR_WIDTH'(DELAY_AFTER);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(INIT_CNT - 1);
  localparam logic [RW-1:0]         RETRY_MAX  = RW'(MAX_RETRY);

  init_state_t           state_r,     state_nxt_s;
  logic [ADDR_WIDTH-1:0] idx_r,       idx_nxt_s;
  logic [RW-1:0]         retry_r,     retry_nxt_s;
  logic [ADDR_WIDTH-1:0] rom_addr_r,  rom_addr_nxt_s;
  logic [15:0]           reg_addr_r,  reg_addr_nxt_s;
  logic [7:0]            data_r,      data_nxt_s;
  logic                  busy_r,      busy_nxt_s;
  logic                  done_r,      done_nxt_s;
  logic                  err_r,       err_nxt_s;
  logic [ADDR_WIDTH-1:0] err_idx_r,   err_idx_nxt_s;
  logic                  wr_req_s;
  logic                  tmr_load_s;
  logic [TW-1:0]         tmr_val_s;
  logic                  tmr_expired_s;

  ov5640_init_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    retry_nxt_s    = retry_r;
    reg_addr_nxt_s = reg_addr_r;
    data_nxt_s     = data_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = done_r;
    err_nxt_s      = err_r;
    err_idx_nxt_s  = err_idx_r;
    wr_req_s       = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_val_s      = {TW{1'b0}};

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          done_nxt_s  = 1'b0;
          err_nxt_s   = 1'b0;
          idx_nxt_s   = {ADDR_WIDTH{1'b0}};
          busy_nxt_s  = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_LATCH;
      end
      ST_LATCH: begin
        reg_addr_nxt_s = rom_q[REG_MSB:REG_LSB];
        data_nxt_s     = rom_q[DAT_MSB:0];
        retry_nxt_s    = {RW{1'b0}};
        state_nxt_s    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!wr_busy) begin
          wr_req_s    = 1'b1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = TO_LOAD;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A completion in the same cycle as the timeout takes precedence
        if (wr_done && !wr_nack) begin
          if (idx_r == DELAY_IDX) begin
            tmr_load_s  = 1'b1;
            tmr_val_s   = DELAY_LOAD;
            state_nxt_s = ST_DELAY;
          end else if (idx_r == LAST_IDX) begin
            done_nxt_s  = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + ADDR_WIDTH'(1);
            state_nxt_s = ST_FETCH;
          end
        end else if (wr_done || tmr_expired_s) begin
          if (retry_r < RETRY_MAX) begin
            retry_nxt_s = retry_r + RW'(1);
            state_nxt_s = ST_ISSUE;
          end else begin
            err_idx_nxt_s = idx_r;
            err_nxt_s     = 1'b1;
            busy_nxt_s    = 1'b0;
            state_nxt_s   = ST_ERROR;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DELAY: begin
        if (tmr_expired_s) begin
          if (idx_r == LAST_IDX) begin
            done_nxt_s  = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_DONE;
          end else begin
            idx_nxt_s   = idx_r + ADDR_WIDTH'(1);
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_DELAY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // The ROM address follows the index so it is valid throughout FETCH
    rom_addr_nxt_s = idx_nxt_s;
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= {ADDR_WIDTH{1'b0}};
      retry_r    <= {RW{1'b0}};
      rom_addr_r <= {ADDR_WIDTH{1'b0}};
      reg_addr_r <= 16'h0000;
      data_r     <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_idx_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      retry_r    <= retry_nxt_s;
      rom_addr_r <= rom_addr_nxt_s;
      reg_addr_r <= reg_addr_nxt_s;
      data_r     <= data_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      err_r      <= err_nxt_s;
      err_idx_r  <= err_idx_nxt_s;
    end
  end

  // The request must reflect wr_busy in the same cycle, so it is decoded
  // from the registered state rather than registered itself.
  assign wr_req      = wr_req_s;
  assign rom_addr    = rom_addr_r;
  assign wr_reg_addr = reg_addr_r;
  assign wr_data     = data_r;
  assign busy        = busy_r;
  assign init_done   = done_r;
  assign init_err    = err_r;
  assign err_index   = err_idx_r;

endmodule

// File: tb/tb_ov5640_init_ctrl.sv
// Directed bench for ov5640_init_ctrl with a 4-entry ROM and a scripted SCCB writer.
module tb_ov5640_init_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_q;
  logic          wr_req;
  logic [15:0]   wr_reg_addr;
  logic [7:0]    wr_data;
  logic          wr_busy;
  logic          wr_done;
  logic          wr_nack;
  logic          busy;
  logic          init_done;
  logic          init_err;
  logic [AW-1:0] err_index;

  logic [23:0] rom [0:3];
  int cyc = 0;
  int n_total = 0;
  int n_pass  = 0;

  int          req_cyc[$];
  logic [23:0] req_dat[$];
  int          done_q[$];
  int          err_q[$];
  int          busy_q[$];
  bit          bad_req   = 1'b0;
  bit          stab_viol = 1'b0;

  int nack_lim[4];
  bit silent[4];

  ov5640_init_ctrl #(
    .INIT_CNT(4), .ADDR_WIDTH(AW), .DELAY_AFTER(1),
    .DELAY_CYCLES(10), .TIMEOUT_CYCLES(20), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_req(wr_req), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .init_done(init_done), .init_err(init_err),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read ROM, one cycle latency
  always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

  // SCCB writer model: answers 5 cycles after each request
  initial begin
    int pend;
    bit pn;
    int att[4];
    int i;
    pend = 0;
    pn = 1'b0;
    att = '{default: 0};
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          wr_done = 1'b1;
          wr_nack = pn;
        end
      end
      #2;
      if (start) att = '{default: 0};
      if (wr_req) begin
        i = int'(wr_data) - 16;
        if (i >= 0 && i < 4) begin
          att[i]++;
          if (!silent[i]) begin
            pend = 5;
            pn = (att[i] <= nack_lim[i]);
          end
        end
      end
    end
  end

  // Event monitor: logs requests and output edges, watches protocol rules
  initial begin
    bit pd, pe, pb, infl;
    logic [23:0] held;
    pd = 1'b0; pe = 1'b0; pb = 1'b0; infl = 1'b0; held = 24'h000000;
    forever begin
      @(negedge clk);
      #2;
      if (wr_req) begin
        req_cyc.push_back(cyc);
        req_dat.push_back({wr_reg_addr, wr_data});
        if (wr_busy) bad_req = 1'b1;
      end
      if (init_done && !pd) done_q.push_back(cyc);
      if (init_err && !pe) err_q.push_back(cyc);
      if (busy && !pb) busy_q.push_back(cyc);
      pd = init_done; pe = init_err; pb = busy;
      if (!reset_n || start) begin
        infl = 1'b0;
      end else begin
        if (wr_req) begin
          infl = 1'b1;
          held = {wr_reg_addr, wr_data};
        end else if (infl && ({wr_reg_addr, wr_data} !== held)) begin
          stab_viol = 1'b1;
        end
        if (wr_done) infl = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(init_done || init_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("end_reached", {31'd0, (init_done || init_err)}, 32'd1);
  endtask

  initial begin
    int s, rb, db, eb, bb;
    reset_n = 1'b0;
    start   = 1'b0;
    wr_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rom[i] = 24'h300010 + 24'(i);
      nack_lim[i] = 0;
      silent[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_reg_addr", {16'd0, wr_reg_addr}, 32'd0);
    chk("rst_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_err", {31'd0, init_err}, 32'd0);
    chk("rst_err_index", {24'd0, err_index}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: nominal run
    rb = req_cyc.size(); db = done_q.size(); bb = busy_q.size();
    run_start(s);
    chk("t1_rom_addr_fetch", {24'd0, rom_addr}, 32'd0);
    wait_end(200);
    chk("t1_nreq", req_cyc.size() - rb, 32'd4);
    if (req_cyc.size() - rb >= 4) begin
      chk("t1_req0_cyc", req_cyc[rb] - s, 32'd3);
      chk("t1_req1_cyc", req_cyc[rb+1] - s, 32'd11);
      chk("t1_req2_cyc", req_cyc[rb+2] - s, 32'd29);
      chk("t1_req3_cyc", req_cyc[rb+3] - s, 32'd37);
      chk("t1_req0_dat", {8'd0, req_dat[rb]}, 32'h300010);
      chk("t1_req1_dat", {8'd0, req_dat[rb+1]}, 32'h300011);
      chk("t1_req2_dat", {8'd0, req_dat[rb+2]}, 32'h300012);
      chk("t1_req3_dat", {8'd0, req_dat[rb+3]}, 32'h300013);
    end
    chk("t1_busy_rise", (busy_q.size() > bb) ? busy_q[bb] - s : -1, 32'd1);
    chk("t1_done_cyc", (done_q.size() > db) ? done_q[db] - s : -1, 32'd43);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_err", {31'd0, init_err}, 32'd0);

    // 2: idx 2 NACKed twice then acked
    nack_lim[2] = 2;
    rb = req_cyc.size(); db = done_q.size();
    run_start(s);
    chk("t2_done_cleared", {31'd0, init_done}, 32'd0);
    wait_end(200);
    chk("t2_nreq", req_cyc.size() - rb, 32'd6);
    if (req_cyc.size() - rb >= 6) begin
      chk("t2_try0_cyc", req_cyc[rb+2] - s, 32'd29);
      chk("t2_try1_cyc", req_cyc[rb+3] - s, 32'd35);
      chk("t2_try2_cyc", req_cyc[rb+4] - s, 32'd41);
      chk("t2_try1_dat", {8'd0, req_dat[rb+3]}, 32'h300012);
      chk("t2_try2_dat", {8'd0, req_dat[rb+4]}, 32'h300012);
      chk("t2_idx3_cyc", req_cyc[rb+5] - s, 32'd49);
    end
    chk("t2_done_cyc", (done_q.size() > db) ? done_q[db] - s : -1, 32'd55);
    chk("t2_err", {31'd0, init_err}, 32'd0);
    nack_lim[2] = 0;

    // 3: idx 3 always NACKed
    nack_lim[3] = 100;
    rb = req_cyc.size(); eb = err_q.size();
    run_start(s);
    wait_end(200);
    chk("t3_nreq", req_cyc.size() - rb, 32'd6);
    if (req_cyc.size() - rb >= 6) begin
      chk("t3_try0_cyc", req_cyc[rb+3] - s, 32'd37);
      chk("t3_try1_cyc", req_cyc[rb+4] - s, 32'd43);
      chk("t3_try2_cyc", req_cyc[rb+5] - s, 32'd49);
      chk("t3_try2_dat", {8'd0, req_dat[rb+5]}, 32'h300013);
    end
    chk("t3_err_cyc", (err_q.size() > eb) ? err_q[eb] - s : -1, 32'd55);
    chk("t3_err", {31'd0, init_err}, 32'd1);
    chk("t3_err_index", {24'd0, err_index}, 32'd3);
    chk("t3_done", {31'd0, init_done}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    nack_lim[3] = 0;

    // 4: idx 0 never answered
    silent[0] = 1'b1;
    rb = req_cyc.size(); eb = err_q.size();
    run_start(s);
    chk("t4_err_cleared", {31'd0, init_err}, 32'd0);
    wait_end(200);
    chk("t4_nreq", req_cyc.size() - rb, 32'd3);
    if (req_cyc.size() - rb >= 3) begin
      chk("t4_try0_cyc", req_cyc[rb] - s, 32'd3);
      chk("t4_try1_cyc", req_cyc[rb+1] - s, 32'd23);
      chk("t4_try2_cyc", req_cyc[rb+2] - s, 32'd43);
    end
    chk("t4_err_cyc", (err_q.size() > eb) ? err_q[eb] - s : -1, 32'd63);
    chk("t4_err_index", {24'd0, err_index}, 32'd0);
    chk("t4_done", {31'd0, init_done}, 32'd0);
    silent[0] = 1'b0;

    // 5: wr_busy holds ISSUE; a second start mid-run is ignored
    rb = req_cyc.size(); db = done_q.size();
    run_start(s);
    @(negedge clk);
    wr_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_hold_addr", {16'd0, wr_reg_addr}, 32'h3000);
    chk("t5_hold_data", {24'd0, wr_data}, 32'h10);
    chk("t5_no_req", {31'd0, wr_req}, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy_kept", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    wr_busy = 1'b0;
    wait_end(200);
    chk("t5_nreq", req_cyc.size() - rb, 32'd4);
    if (req_cyc.size() - rb >= 4) begin
      chk("t5_req0_cyc", req_cyc[rb] - s, 32'd10);
      chk("t5_req1_cyc", req_cyc[rb+1] - s, 32'd18);
      chk("t5_req3_cyc", req_cyc[rb+3] - s, 32'd44);
    end
    chk("t5_done_cyc", (done_q.size() > db) ? done_q[db] - s : -1, 32'd50);

    // 6: reset in WAIT at idx 2, late wr_done, then a fresh run
    rb = req_cyc.size();
    run_start(s);
    repeat (30) @(negedge clk);
    chk("t6_in_wait_idx2", {24'd0, wr_data}, 32'h12);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("t6_rst_reg_addr", {16'd0, wr_reg_addr}, 32'd0);
    chk("t6_rst_data", {24'd0, wr_data}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("t6_rst_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("t6_late_done_ignored_busy", {31'd0, busy}, 32'd0);
    chk("t6_late_done_ignored_req", req_cyc.size() - rb, 32'd3);
    chk("t6_late_done_ignored_done", {31'd0, init_done}, 32'd0);
    rb = req_cyc.size(); db = done_q.size();
    run_start(s);
    wait_end(200);
    chk("t6_nreq", req_cyc.size() - rb, 32'd4);
    if (req_cyc.size() - rb >= 1) begin
      chk("t6_req0_cyc", req_cyc[rb] - s, 32'd3);
      chk("t6_req0_dat", {8'd0, req_dat[rb]}, 32'h300010);
    end
    chk("t6_done_cyc", (done_q.size() > db) ? done_q[db] - s : -1, 32'd43);

    // Protocol rules over the whole run
    chk("req_while_busy", {31'd0, bad_req}, 32'd0);
    chk("addr_data_stable", {31'd0, stab_viol}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ov5640_init_ctrl.md
# ov5640_init_ctrl

Sequencer that walks the OV5640 JPEG init register table (24-bit entries, `{reg_addr[15:0], data[7:0]}`, synchronous-read ROM, 1-cycle latency) and issues one SCCB write per entry to the SCCB write engine. It inserts the mandatory post-software-reset delay and retries NACKed writes. It handles per-write timeouts. It reports completion or failure to the camera top level. It sits between the init table ROM and the SCCB master.

## Interface
- `INIT_CNT`, 250: number of table entries to send (indices 0..INIT_CNT-1).
- `ADDR_WIDTH`, 8: ROM address width.
- `DELAY_AFTER`, 1: index of the entry after which the delay is inserted (software reset).
- `DELAY_CYCLES`, 250000: delay length in clk cycles (5 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 100000: maximum wait for `wr_done` per write attempt.
- `MAX_RETRY`, 3: retries per entry after the first attempt.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sequence from index 0.
- `rom_addr`  out  ADDR_WIDTH  registered ROM address.
- `rom_q`  in  24  ROM data, valid one cycle after `rom_addr` is sampled.
- `wr_req`  out  1  one-cycle write request to the SCCB engine.
- `wr_reg_addr`  out  16  register address; held stable from `wr_req` until `wr_done`.
- `wr_data`  out  8  register data; held stable from `wr_req` until `wr_done`.
- `wr_busy`  in  1  SCCB engine busy; `wr_req` is never issued while high.
- `wr_done`  in  1  one-cycle pulse at the end of a transaction.
- `wr_nack`  in  1  qualified by `wr_done`; 1 means the slave NACKed.
- `busy`  out  1  high from `start` acceptance until DONE or ERROR.
- `init_done`  out  1  sticky; high after the last entry is acknowledged.
- `init_err`  out  1  sticky; high after retries are exhausted.
- `err_index`  out  ADDR_WIDTH  index of the failing entry; valid when `init_err` is high.

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, DELAY, DONE, ERROR.
- IDLE, DONE, ERROR:
  - `start` → clear `init_done`, `init_err`, and `idx`; set `busy`; go to FETCH.
  - `start` is ignored in all other states.
- FETCH: `rom_addr`=`idx`; go to LATCH.
- LATCH: capture `rom_q[23:8]`→`wr_reg_addr` and `rom_q[7:0]`→`wr_data`; clear `retry`; go to ISSUE.
- ISSUE: if `wr_busy`=0, pulse `wr_req`, load the timer with TIMEOUT_CYCLES, go to WAIT. Otherwise stay.
- WAIT, with `wr_done` and `wr_nack`=0:
  - `idx`==DELAY_AFTER → load the timer with DELAY_CYCLES, go to DELAY.
  - `idx`==INIT_CNT-1 → go to DONE.
  - otherwise → `idx`+1, go to FETCH.
- WAIT, with `wr_done` and `wr_nack`=1, or timer expiry: this is a failure.
  - `retry`<MAX_RETRY → `retry`+1, go to ISSUE (same address and data; no refetch).
  - otherwise → `err_index`=`idx`, set `init_err`, go to ERROR.
- If `wr_done` and timer expiry occur in the same cycle, `wr_done` wins.
- DELAY: on timer expiry, apply the same idx/last-entry check as a successful write, but skip the DELAY_AFTER check.
  - DELAY_AFTER==INIT_CNT-1 → delay, then DONE.
- DONE: `init_done`=1, `busy`=0.
- ERROR: `init_err`=1, `busy`=0.
- Widths:
  - `idx` is ADDR_WIDTH bits and never exceeds INIT_CNT-1 (no wrap).
  - Timer width is `$clog2(max(DELAY_CYCLES, TIMEOUT_CYCLES)+1)`.
  - `retry` width is `$clog2(MAX_RETRY+1)`.
- Reset (including mid-sequence):
  - All outputs go to 0 and the state goes to IDLE.
  - An in-flight SCCB transaction is abandoned; a `wr_done` arriving later in IDLE is ignored.

## Timing
- `start` at cycle 0:
  - FETCH at cycle 1, LATCH at 2, ISSUE at 3.
  - `wr_req` at 3 at the earliest (`wr_busy`=0).
- Write-to-write gap:
  - `wr_done` at cycle n → FETCH n+1 → next `wr_req` at n+3 at the earliest.
- Delay: `wr_done` for DELAY_AFTER at cycle n → FETCH at n+1+DELAY_CYCLES.
- Timeout: declared at cycle m+TIMEOUT_CYCLES when `wr_req` was at cycle m and no `wr_done` arrived.
- `init_done` rises the cycle after the final `wr_done` (ack), and `busy` falls in the same cycle.
- `wr_req` is exactly one cycle wide and only asserted in ISSUE.

## Structure
- Package `ov5640_init_pkg` holds:
  - the state enum `init_state_t`;
  - localparams for field slicing (`REG_MSB`=23, `REG_LSB`=8, `DAT_MSB`=7);
  - the default DELAY_CYCLES and TIMEOUT_CYCLES values.
- Sub-module `ov5640_init_timer`: a loadable down-counter shared by DELAY and the WAIT timeout.
  - Inputs: `load`, `load_val`.
  - Output: `expired` (one-cycle pulse when the count reaches 0).

## Test plan
Benches use INIT_CNT=4, DELAY_AFTER=1, DELAY_CYCLES=10, TIMEOUT_CYCLES=20, MAX_RETRY=2, and a ROM model with `rom[i]`=24'h3000_10+i.

1. Nominal run: `start`, writer acks each write 5 cycles after `wr_req` → 4 writes, data 10..13, 10-cycle gap after idx 1, `init_done`=1, `init_err`=0.
2. NACK recovery: writer NACKs idx 2 twice, then acks → 3 `wr_req` for 24'h3000_12, then `init_done`=1.
3. NACK exhaustion: writer always NACKs idx 3 → 3 attempts, then `init_err`=1, `err_index`=3, `init_done`=0.
4. Timeout: writer never answers idx 0 → `wr_req` at cycle 3, 23, and 43, then `init_err`=1 at cycle 63, `err_index`=0.
5. Busy hold and start-while-busy: `wr_busy` high for 7 cycles during ISSUE → `wr_req` deferred and address/data stable; a second `start` mid-run has no effect.
6. Reset mid-WAIT at idx 2 → all outputs 0; a late `wr_done` is ignored; a new `start` writes from idx 0.
